// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall vector plus a RUN/HOLD branch redirect FSM.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [5:0]  stall,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] pc_target_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] branch_cnt_o,
    output logic        o_dbg_state
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_redirect;
    logic        r_flush;
    logic [31:0] r_target;
    logic        w_accept;

    // A stalled stage freezes every stage in front of it, so the latest requester wins.
    always_comb begin
        stall = 6'b000000;
        if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (stallreq_ex) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else if (stallreq_if) begin
            stall = 6'b000011;
        end
    end

    assign w_accept = (r_state == RUN) && branch_flag_i && !stall[2];

    // Handshake: a branch is taken when branch_flag_i is high, ID is not stalled and the FSM
    // is in RUN; the redirect is then held until the PC is free to load the target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_redirect <= 1'b0;
            r_flush    <= 1'b0;
            r_target   <= 32'h0000_0000;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        r_state    <= HOLD;
                        r_redirect <= 1'b1;
                        r_flush    <= 1'b1;
                        r_target   <= branch_target_i;
                    end
                end
                HOLD: begin
                    if (!stall[0]) begin
                        r_state    <= RUN;
                        r_redirect <= 1'b0;
                        r_flush    <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    r_redirect <= 1'b0;
                    r_flush    <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_o  = r_redirect;
    assign flush_o     = r_flush;
    assign pc_target_o = r_target;
    assign o_dbg_state = (r_state == HOLD);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_branch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= 32'h0000_0000;
            r_branch_cnt <= 32'h0000_0000;
        end else begin
            if ((stall != 6'b000000) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign branch_cnt_o = r_branch_cnt;
`else
    assign stall_cnt_o  = 32'h0000_0000;
    assign branch_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed stimulus for pipe_ctrl, checked by a queue-based scoreboard
// against a stage-depth reference model of stall priority and branch redirect.
module tb_pipe_ctrl;

    localparam int W = 105;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] pc_target_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] branch_cnt_o;
    logic        o_dbg_state;

    pipe_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_id    (stallreq_id),
        .stallreq_ex    (stallreq_ex),
        .stallreq_mem   (stallreq_mem),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .stall          (stall),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .pc_target_o    (pc_target_o),
        .stall_cnt_o    (stall_cnt_o),
        .branch_cnt_o   (branch_cnt_o),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Scoreboard entry: {stall, redirect, flush, target, stall_cnt, branch_cnt, hold}
    logic [W-1:0] exp_q[$];

    // Reference model state
    bit          m_hold;
    logic [31:0] m_tgt;
    logic [31:0] m_scnt;
    logic [31:0] m_bcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // The stall vector freezes every stage up to and including the deepest requester.
    function automatic logic [5:0] model_stall(input logic [3:0] req);
        int depth;
        int v;
        depth = 0;
        if (req[0]) depth = 2;
        if (req[1]) depth = 3;
        if (req[2]) depth = 4;
        if (req[3]) depth = 5;
        v = (1 << depth) - 1;
        return v[5:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Driver: req = {mem, ex, id, if}; applies one cycle of inputs and predicts the outcome.
    task automatic step(input logic [3:0] req, input logic bf, input logic [31:0] tgt);
        logic [5:0] es;
        bit acc;
        @(negedge clk);
        stallreq_if     = req[0];
        stallreq_id     = req[1];
        stallreq_ex     = req[2];
        stallreq_mem    = req[3];
        branch_flag_i   = bf;
        branch_target_i = tgt;
        es  = model_stall(req);
        acc = !m_hold && bf && (es[2] == 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        if (es != 6'd0) m_scnt = sat_inc(m_scnt);
        if (acc) m_bcnt = sat_inc(m_bcnt);
`endif
        if (m_hold) begin
            if (es[0] == 1'b0) m_hold = 1'b0;
        end else if (acc) begin
            m_hold = 1'b1;
            m_tgt  = tgt;
        end
        exp_q.push_back({es, m_hold, m_hold, m_tgt, m_scnt, m_bcnt, m_hold});
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input logic [3:0] req);
        @(negedge clk);
        #1;
        rst          = 1'b1;
        stallreq_if  = req[0];
        stallreq_id  = req[1];
        stallreq_ex  = req[2];
        stallreq_mem = req[3];
        #1;
        chk("rst_redirect", {31'd0, redirect_o}, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_target", pc_target_o, 32'd0);
        chk("rst_state", {31'd0, o_dbg_state}, 32'd0);
        chk("rst_stall_comb", {26'd0, stall}, {26'd0, model_stall(req)});
        chk("rst_stall_cnt", stall_cnt_o, 32'd0);
        chk("rst_branch_cnt", branch_cnt_o, 32'd0);
        m_hold = 1'b0;
        m_tgt  = 32'd0;
        m_scnt = 32'd0;
        m_bcnt = 32'd0;
        @(negedge clk);
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_ex   = 1'b0;
        stallreq_mem  = 1'b0;
        branch_flag_i = 1'b0;
        rst           = 1'b0;
    endtask

    // Monitor: after every edge, compare the DUT against the oldest prediction.
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", {26'd0, stall}, {26'd0, e[104:99]});
            chk("redirect", {31'd0, redirect_o}, {31'd0, e[98]});
            chk("flush", {31'd0, flush_o}, {31'd0, e[97]});
            chk("pc_target", pc_target_o, e[96:65]);
            chk("stall_cnt", stall_cnt_o, e[64:33]);
            chk("branch_cnt", branch_cnt_o, e[32:1]);
            chk("state", {31'd0, o_dbg_state}, {31'd0, e[0]});
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        rst             = 1'b1;
        stallreq_if     = 1'b0;
        stallreq_id     = 1'b0;
        stallreq_ex     = 1'b0;
        stallreq_mem    = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'd0;
        m_hold = 1'b0;
        m_tgt  = 32'd0;
        m_scnt = 32'd0;
        m_bcnt = 32'd0;

        do_reset(4'b0001);

        // Priority: if+ex gives ex's vector, then release
        step(4'b0101, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0);
        step(4'b1001, 1'b0, 32'd0);
        step(4'b0010, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0);

        // Plain branch
        step(4'b0000, 1'b1, 32'h0000_0100);
        step(4'b0000, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0);

        // Branch during a 3-cycle fetch stall
        step(4'b0001, 1'b1, 32'h0000_0200);
        step(4'b0001, 1'b1, 32'h0000_0AAA);
        step(4'b0001, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0);

        // Branch blocked by a memory stall, then accepted
        step(4'b1000, 1'b1, 32'h0000_0300);
        step(4'b1000, 1'b1, 32'h0000_0300);
        step(4'b0000, 1'b1, 32'h0000_0300);
        step(4'b0000, 1'b0, 32'd0);

        // Reset while in HOLD
        step(4'b0000, 1'b1, 32'h0000_0400);
        do_reset(4'b0001);

        // Counter scenario: 5 stalled cycles and 2 branches
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b0, 32'd0);
        step(4'b0000, 1'b1, 32'h0000_0500);
        step(4'b0000, 1'b0, 32'd0);
        step(4'b0000, 1'b1, 32'h0000_0600);
        step(4'b0000, 1'b0, 32'd0);
        drain();
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cnt", stall_cnt_o, 32'd5);
        chk("perf_branch_cnt", branch_cnt_o, 32'd2);
`else
        chk("perf_stall_cnt", stall_cnt_o, 32'd0);
        chk("perf_branch_cnt", branch_cnt_o, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r[0] = ($urandom_range(0, 3) == 0);
            r[1] = ($urandom_range(0, 5) == 0);
            r[2] = ($urandom_range(0, 5) == 0);
            r[3] = ($urandom_range(0, 5) == 0);
            step(r, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
        end
        step(4'b0000, 1'b0, 32'd0);
        step(4'b0000, 1'b0, 32'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset (`RstEnable = 1).
REQ-003 SHALL have port stallreq_if, input, 1 bit: instruction fetch not complete.
REQ-004 SHALL have port stallreq_id, input, 1 bit: load-use hazard detected in ID.
REQ-005 SHALL have port stallreq_ex, input, 1 bit: multi-cycle EX operation busy.
REQ-006 SHALL have port stallreq_mem, input, 1 bit: data memory access not complete.
REQ-007 SHALL have port branch_flag_i, input, 1 bit: ID resolves a taken branch or jump.
REQ-008 SHALL have port branch_target_i, input, `RegBus (32 bits): target address of that branch.
REQ-009 SHALL have port stall, output, 6 bits: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; `Stop = 1.
REQ-010 SHALL have port flush_o, output, 1 bit: IF/ID register loads a bubble.
REQ-011 SHALL have port redirect_o, output, 1 bit: PC loads pc_target_o instead of PC+4.
REQ-012 SHALL have port pc_target_o, output, `RegBus: latched branch target.
REQ-013 SHALL have ports stall_cnt_o and branch_cnt_o, outputs, 32 bits each: performance counters.

Function
REQ-014 SHALL drive stall combinationally from the highest requesting stage: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-015 SHALL give a simultaneous request from a later stage priority over an earlier stage (e.g. if+mem -> 6'b011111).
REQ-016 SHALL implement FSM states RUN and HOLD, in a registered state.
REQ-017 SHALL accept a branch in RUN only when branch_flag_i = 1 and stall[2] = `NoStop in the same cycle.
REQ-018 SHALL, on acceptance, latch branch_target_i into pc_target_o and enter HOLD on the next edge.
REQ-019 SHALL, in HOLD, assert redirect_o = 1 and flush_o = 1; both SHALL be 0 in RUN.
REQ-020 SHALL stay in HOLD while stall[0] = `Stop, keeping pc_target_o stable.
REQ-021 SHALL return HOLD -> RUN on the edge where stall[0] = `NoStop (the PC takes the target); redirect latency SHALL be 1 cycle minimum after acceptance.
REQ-022 SHALL ignore branch_flag_i while in HOLD (ID holds wrong-path or bubble).
REQ-023 SHALL not accept a branch while ID is stalled; branch_flag_i is re-evaluated each cycle until accepted.

Reset
REQ-024 SHALL, while rst = 1, force state RUN, pc_target_o = `ZeroWord and counters = 0, regardless of clk.
REQ-025 SHALL, on reset asserted in HOLD, drop redirect_o and flush_o immediately and discard the pending target.
REQ-026 SHALL keep the stall output purely combinational from the requests during and after reset.

Configuration
REQ-027 SHALL compile the performance counters only when macro PIPE_CTRL_PERF_EN is defined.
REQ-028 SHALL, with PIPE_CTRL_PERF_EN, increment stall_cnt_o each cycle stall != 0 and branch_cnt_o per accepted branch, each saturating at 32'hFFFFFFFF.
REQ-029 SHALL, without PIPE_CTRL_PERF_EN, keep both counter ports present and tied to `ZeroWord with no counter flops.

Verification
REQ-030 SHALL cover priority: stallreq_if=1, stallreq_ex=1 -> stall = 6'b001111; release all -> 6'b000000 same cycle.
REQ-031 SHALL cover a plain branch: branch_flag_i=1, target 32'h00000100, no stalls -> next cycle redirect_o=1, flush_o=1, pc_target_o=32'h100; following cycle RUN.
REQ-032 SHALL cover a branch during fetch stall: stallreq_if=1 for 3 cycles across acceptance of target 32'h200 -> HOLD held 3 cycles, exit on the first cycle stallreq_if=0.
REQ-033 SHALL cover a blocked branch: branch_flag_i=1 with stallreq_mem=1 for 2 cycles -> no acceptance; accepted on the first cycle stallreq_mem=0.
REQ-034 SHALL cover reset in HOLD: rst=1 mid-HOLD -> redirect_o=0 and pc_target_o=0 before the next clk edge.
REQ-035 SHALL cover PIPE_CTRL_PERF_EN: 5 stalled cycles plus 2 branches -> stall_cnt_o=5, branch_cnt_o=2; without the macro both read 0.
